fetch_sequencer: RTL and testbench

//  Front-end stage feeding the combinational control decoder: owns PC, instruction register,

---
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end stage feeding the combinational control decoder.
// Owns the program counter, instruction register, execute-cycle bit and carry
// flag. Fetches one instruction byte per req/ack handshake, then holds it for
// one execute cycle, or two when the decoder asserts mc, and commits the next
// PC (sequential or jump) at the end of the last execute cycle.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   imem_addr     fetch address (always equals pc)
//   imem_req      fetch request, high only while fetching
//   imem_ack      memory returns imem_data this cycle
//   imem_data     instruction byte, captured on req & ack
//   mc            decoder: instruction needs a second execute cycle
//   jump          decoder: take jump_target at commit
//   jump_target   jump destination
//   wc            decoder: write carry_in to the carry flag this execute cycle
//   carry_in      ALU carry-out
//   inst          instruction register
//   cycle         execute cycle index (0 first, 1 second)
//   carry         carry flag register
//   pc            address of the instruction held in inst
//   inst_valid    high while executing; decoder outputs only meaningful then
module fetch_sequencer #(
  parameter int unsigned       PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  input  logic            mc,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            wc,
  input  logic            carry_in,
  output logic [7:0]      inst,
  output logic            cycle,
  output logic            carry,
  output logic [PC_W-1:0] pc,
  output logic            inst_valid
);

  localparam logic [0:0] StFetch = 1'b0;
  localparam logic [0:0] StExec  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      inst_q, inst_d;
  logic            cycle_q, cycle_d;
  logic            carry_q, carry_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cycle_d = cycle_q;
    carry_d = carry_q;
    unique case (state_q)
      StFetch: begin
        // Decoder inputs are meaningless here; only the handshake matters.
        if (imem_ack) begin
          inst_d  = imem_data;
          cycle_d = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        // Either execute cycle may update carry.
        if (wc) begin
          carry_d = carry_in;
        end
        if (!cycle_q && mc) begin
          // First half of a two-cycle instruction: jump is not yet final.
          cycle_d = 1'b1;
        end else begin
          pc_d    = jump ? jump_target : pc_q + PC_W'(1);
          cycle_d = 1'b0;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      inst_q  <= 8'h00;
      cycle_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cycle_q <= cycle_d;
      carry_q <= carry_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == StFetch);
  assign inst_valid = (state_q == StExec);
  assign inst       = inst_q;
  assign cycle      = cycle_q;
  assign carry      = carry_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int unsigned PC_W = 16;
  localparam logic [15:0] RPC  = 16'h0100;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [7:0]      imem_data;
  logic            mc;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            wc;
  logic            carry_in;
  logic [7:0]      inst;
  logic            cycle;
  logic            carry;
  logic [PC_W-1:0] pc;
  logic            inst_valid;

  int total = 0;
  int bad   = 0;

  // Architectural view of the machine, updated per instruction.
  logic [15:0] m_pc;
  logic [7:0]  m_inst;
  logic        m_carry;

  fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .mc          (mc),
    .jump        (jump),
    .jump_target (jump_target),
    .wc          (wc),
    .carry_in    (carry_in),
    .inst        (inst),
    .cycle       (cycle),
    .carry       (carry),
    .pc          (pc),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_data   = 8'h00;
    mc          = 1'b0;
    jump        = 1'b0;
    jump_target = '0;
    wc          = 1'b0;
    carry_in    = 1'b0;
  endtask

  // {req, valid, addr, pc, inst, cycle, carry}
  function automatic logic [43:0] snap();
    return {imem_req, inst_valid, imem_addr, pc, inst, cycle, carry};
  endfunction

  task automatic test_reset();
    logic [43:0] exp;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    exp = {1'b1, 1'b0, RPC, RPC, 8'h00, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", snap(), exp);
    end
    rst = 1'b0;
    step();
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", snap(), exp);
    end
    m_pc = RPC; m_inst = 8'h00; m_carry = 1'b0;
  endtask

  task automatic test_basic();
    logic [43:0] exp;
    imem_ack = 1'b1; imem_data = 8'h12;
    step();
    imem_ack = 1'b0;
    exp = {1'b0, 1'b1, 16'h0100, 16'h0100, 8'h12, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL basic_exec: got %h want %h", snap(), exp);
    end
    step();
    exp = {1'b1, 1'b0, 16'h0101, 16'h0101, 8'h12, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL basic_commit: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_multicycle();
    logic [43:0] exp;
    imem_ack = 1'b1; imem_data = 8'h34;
    step();
    imem_ack = 1'b0;
    exp = {1'b0, 1'b1, 16'h0101, 16'h0101, 8'h34, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL mc_cycle0: got %h want %h", snap(), exp);
    end
    mc = 1'b1; jump = 1'b1; jump_target = 16'h2000;
    step();
    mc = 1'b0; jump = 1'b0;
    exp = {1'b0, 1'b1, 16'h0101, 16'h0101, 8'h34, 1'b1, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL mc_cycle1: got %h want %h", snap(), exp);
    end
    step();
    exp = {1'b1, 1'b0, 16'h0102, 16'h0102, 8'h34, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL mc_commit: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_jump();
    logic [43:0] exp;
    imem_ack = 1'b1; imem_data = 8'h56;
    step();
    imem_ack = 1'b0;
    mc = 1'b1; jump = 1'b1; jump_target = 16'h2000;
    step();
    exp = {1'b0, 1'b1, 16'h0102, 16'h0102, 8'h56, 1'b1, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL jump_ignored_c0: got %h want %h", snap(), exp);
    end
    step();
    idle_inputs();
    exp = {1'b1, 1'b0, 16'h2000, 16'h2000, 8'h56, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL jump_taken: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_ack_wait();
    logic [43:0] exp;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b0; imem_data = 8'($urandom);
      exp = {1'b1, 1'b0, 16'h2000, 16'h2000, 8'h56, 1'b0, 1'b0};
      total++;
      if (snap() !== exp) begin
        bad++;
        $display("FAIL wait_%0d: got %h want %h", i, snap(), exp);
      end
      step();
    end
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL wait_req4: got %b want 1", imem_req);
    end
    imem_ack = 1'b1; imem_data = 8'h9A;
    step();
    // Spurious ack with different data during both execute cycles.
    imem_data = 8'hFF; mc = 1'b1;
    exp = {1'b0, 1'b1, 16'h2000, 16'h2000, 8'h9A, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL wait_capture: got %h want %h", snap(), exp);
    end
    step();
    exp = {1'b0, 1'b1, 16'h2000, 16'h2000, 8'h9A, 1'b1, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL spurious_ack: got %h want %h", snap(), exp);
    end
    imem_ack = 1'b0; mc = 1'b0;
    step();
    exp = {1'b1, 1'b0, 16'h2001, 16'h2001, 8'h9A, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL wait_commit: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_carry_wrap();
    logic [43:0] exp;
    imem_ack = 1'b1; imem_data = 8'h01;
    step();
    imem_ack = 1'b0;
    wc = 1'b1; carry_in = 1'b1; jump = 1'b1; jump_target = 16'hFFFF;
    step();
    exp = {1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 8'h01, 1'b0, 1'b1};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL carry_set: got %h want %h", snap(), exp);
    end
    // wc in fetch must not touch carry.
    jump = 1'b0; wc = 1'b1; carry_in = 1'b0;
    imem_ack = 1'b1; imem_data = 8'h02;
    step();
    imem_ack = 1'b0; wc = 1'b0; carry_in = 1'b0;
    total++;
    if (carry !== 1'b1) begin
      bad++;
      $display("FAIL carry_fetch_wc: got %b want 1", carry);
    end
    step();
    exp = {1'b1, 1'b0, 16'h0000, 16'h0000, 8'h02, 1'b0, 1'b1};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL pc_wrap_carry_hold: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [43:0] exp;
    imem_ack = 1'b1; imem_data = 8'h77;
    step();
    imem_ack = 1'b0; mc = 1'b1; wc = 1'b1; carry_in = 1'b1;
    step();
    idle_inputs();
    exp = {1'b0, 1'b1, 16'h0000, 16'h0000, 8'h77, 1'b1, 1'b1};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL pre_reset: got %h want %h", snap(), exp);
    end
    #2;
    rst = 1'b1;
    #1;
    exp = {1'b1, 1'b0, RPC, RPC, 8'h00, 1'b0, 1'b0};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", snap(), exp);
    end
    #1;
    rst = 1'b0;
    step();
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL post_reset: got %h want %h", snap(), exp);
    end
    m_pc = RPC; m_inst = 8'h00; m_carry = 1'b0;
  endtask

  // Instruction-level reference: each instruction is a wait count, a byte,
  // a length of 1 or 2 execute cycles, carry writes, and a final PC choice.
  task automatic test_random();
    logic [43:0] exp;
    int          waits;
    logic [7:0]  d;
    logic        two;
    logic        jmp;
    logic [15:0] tgt;
    int          ncyc;
    for (int n = 0; n < 40; n++) begin
      waits = int'($urandom_range(0, 3));
      d     = 8'($urandom);
      two   = 1'($urandom);
      jmp   = 1'($urandom);
      tgt   = 16'($urandom);
      ncyc  = two ? 2 : 1;
      for (int w = 0; w <= waits; w++) begin
        imem_ack  = (w == waits);
        imem_data = (w == waits) ? d : 8'($urandom);
        mc = 1'($urandom); jump = 1'($urandom); jump_target = 16'($urandom);
        wc = 1'($urandom); carry_in = 1'($urandom);
        exp = {1'b1, 1'b0, m_pc, m_pc, m_inst, 1'b0, m_carry};
        total++;
        if (snap() !== exp) begin
          bad++;
          $display("FAIL rnd_fetch n=%0d w=%0d: got %h want %h", n, w, snap(), exp);
        end
        step();
      end
      m_inst = d;
      for (int c = 0; c < ncyc; c++) begin
        imem_ack  = 1'($urandom);
        imem_data = 8'($urandom);
        mc        = (c == 0) ? two : 1'($urandom);
        jump      = (c == ncyc - 1) ? jmp : 1'($urandom);
        jump_target = (c == ncyc - 1) ? tgt : 16'($urandom);
        wc        = 1'($urandom);
        carry_in  = 1'($urandom);
        exp = {1'b0, 1'b1, m_pc, m_pc, m_inst, 1'(c), m_carry};
        total++;
        if (snap() !== exp) begin
          bad++;
          $display("FAIL rnd_exec n=%0d c=%0d: got %h want %h", n, c, snap(), exp);
        end
        if (wc) m_carry = carry_in;
        step();
      end
      m_pc = jmp ? tgt : m_pc + 16'd1;
    end
    idle_inputs();
    exp = {1'b1, 1'b0, m_pc, m_pc, m_inst, 1'b0, m_carry};
    total++;
    if (snap() !== exp) begin
      bad++;
      $display("FAIL rnd_final: got %h want %h", snap(), exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_multicycle();
    test_jump();
    test_ack_wait();
    test_carry_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
